// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared types and constants for the register-file write-port arbiter.
//   REG_AW / REG_DW / NREG : register file geometry (32 x 32, r0 hardwired 0)
//   REG_ZERO               : address of the hardwired-zero register
//   MAX_WAIT_DEF / CNT_W_DEF : default starvation threshold and counter width
//   gnt_e                  : which requester owns the write port this cycle
//   wr_req_t               : one write-port request (enable, address, data)
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREG   = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W_DEF    = 3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2
  } gnt_e;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

  // A write only reaches the array when enabled and not aimed at r0.
  function automatic logic commits(input wr_req_t req);
    return req.en && (req.addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// -----------------------------------------------------------------------------
// rf_busy_table
// Scoreboard of registers with an outstanding MDU write.
//   clk, resetn      : clock / synchronous active-low reset
//   set_en_i, set_idx_i : reserve a destination (MDU issue)
//   clr_en_i, clr_idx_i : release a destination (MDU writeback handshake)
//   rs_i, rt_i       : decode read addresses
//   rs_busy_o, rt_busy_o : registered busy bits for rs / rt (no bypass)
// Set beats clear on the same bit in the same cycle, so a back-to-back
// reissue to the register just being written stays reserved.
// -----------------------------------------------------------------------------
module rf_busy_table
  import rf_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  output logic              rs_busy_o,
  output logic              rt_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;  // applied last: set wins
    busy_d[0] = 1'b0;                        // r0 can never be pending
  end

  always_ff @(posedge clk) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign rs_busy_o = busy_q[rs_i];
  assign rt_busy_o = busy_q[rt_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Owns the single write port of the 32x32 general register file.
//   clk, resetn                     : clock / synchronous active-low reset
//   pipe_wen/pipe_waddr/pipe_wdata  : in-order writeback, fixed priority
//   mdu_valid/mdu_waddr/mdu_wdata   : MDU result, valid/ready handshake
//   mdu_ready                       : MDU result accepted this cycle
//   issue_en/issue_dst              : MDU issue, reserves a destination
//   rs/rt, rs_busy/rt_busy          : RAW-hazard lookup for decode
//   pipe_stall                      : pipeline must bubble its writeback
//   Regwen/waddr/wdata              : register file write port (same edge)
// The pipeline normally wins; if the MDU is blocked long enough, pipe_stall
// forces a bubble so the MDU result drains.
// -----------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,  // 1..7
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pipe_wen,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [REG_DW-1:0] pipe_wdata,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_waddr,
  input  logic [REG_DW-1:0] mdu_wdata,
  output logic              mdu_ready,
  input  logic              issue_en,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              pipe_stall,
  output logic              Regwen,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_DW-1:0] wdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  gnt_e             gnt;
  wr_req_t          wr;
  logic             hs;
  logic             rs_busy_raw, rt_busy_raw;

  // ---------------------------------------------------------------------------
  // Grant. Nothing is granted while in reset, which also discards any MDU
  // handshake that would otherwise have completed on that edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = GNT_NONE;
    if (resetn) begin
      if (!stall_q && pipe_wen) gnt = GNT_PIPE;
      else if (mdu_valid)       gnt = GNT_MDU;
    end
  end

  always_comb begin
    wr = '0;
    case (gnt)
      GNT_PIPE: wr = '{en: 1'b1, addr: pipe_waddr, data: pipe_wdata};
      GNT_MDU:  wr = '{en: 1'b1, addr: mdu_waddr,  data: mdu_wdata};
      default:  wr = '0;
    endcase
  end

  assign Regwen    = commits(wr);
  assign waddr     = wr.addr;
  assign wdata     = wr.data;
  // An MDU result for r0 still handshakes; it is simply not committed.
  assign mdu_ready = (gnt == GNT_MDU);
  assign hs        = mdu_valid && mdu_ready;

  // ---------------------------------------------------------------------------
  // Starvation counter and stall. The counter saturates at MAX_WAIT; the
  // stall is raised on the edge that ends the MAX_WAIT-th blocked cycle.
  // Once stalled the MDU is always granted, so the stall lasts until the
  // handshake or until the MDU withdraws.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (!mdu_valid || hs) begin
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_SET) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Pipeline writes never touch it.
  // ---------------------------------------------------------------------------
  rf_busy_table u_busy (
    .clk       (clk),
    .resetn    (resetn),
    .set_en_i  (issue_en && (issue_dst != REG_ZERO)),
    .set_idx_i (issue_dst),
    .clr_en_i  (hs && (mdu_waddr != REG_ZERO)),
    .clr_idx_i (mdu_waddr),
    .rs_i      (rs),
    .rt_i      (rt),
    .rs_busy_o (rs_busy_raw),
    .rt_busy_o (rt_busy_raw)
  );

  // Registered state reads as cleared for the whole time reset is held.
  assign rs_busy    = resetn && rs_busy_raw;
  assign rt_busy    = resetn && rt_busy_raw;
  assign pipe_stall = resetn && stall_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Controller for the 32x32 general register file's single write port (r0 hardwired to zero).
- Shares the port between two requesters:
  - the in-order pipeline writeback stage, which has fixed priority and never waits;
  - the multicycle multiply/divide unit (MDU), which uses a valid/ready handshake.
- Keeps a busy scoreboard of MDU destinations so decode can stall on RAW hazards.
- Forces a pipeline bubble if the MDU is starved.

Parameters:
- MAX_WAIT, 4: cycles an MDU request may be blocked before pipe_stall is raised (legal range 1..7).
- CNT_W, 3: width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous reset, active low
- pipe_wen  in  1  pipeline writeback request
- pipe_waddr  in  5  pipeline destination register
- pipe_wdata  in  32  pipeline write data
- mdu_valid  in  1  MDU result valid
- mdu_waddr  in  5  MDU destination register
- mdu_wdata  in  32  MDU result
- mdu_ready  out  1  MDU result accepted this cycle
- issue_en  in  1  MDU op issued this cycle (reserves destination)
- issue_dst  in  5  destination reserved by issue
- rs  in  5  decode source 1
- rt  in  5  decode source 2
- rs_busy  out  1  rs has a pending MDU write
- rt_busy  out  1  rt has a pending MDU write
- pipe_stall  out  1  pipeline must insert a writeback bubble
- Regwen  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  32  register file write data

Behaviour:
- Single clock domain; the reset is synchronous and active-low on resetn.
- Reset state (while resetn=0 and on the first cycle after):
  - busy vector = 0; starvation counter = 0; pipe_stall = 0.
  - Combinational outputs are forced off during reset: Regwen = 0, mdu_ready = 0.
- Write-port mux is combinational, zero latency; the register file commits on the same rising edge.
- Grant rules, evaluated each cycle:
  - pipe_stall=0 and pipe_wen=1: pipeline wins. Regwen/waddr/wdata come from pipe_*; mdu_ready=0.
  - Otherwise, if mdu_valid=1: MDU wins. mdu_ready=1; Regwen/waddr/wdata come from mdu_*.
  - Neither requesting: Regwen=0; waddr and wdata = 0.
- Handshake: MDU transfer completes when mdu_valid & mdu_ready at the clock edge. The MDU must hold mdu_waddr/mdu_wdata stable until then.
- Register $0: if the granted address is 0, Regwen=0. An MDU request to $0 still handshakes (mdu_ready=1) and changes no busy bit.
- Starvation counter:
  - Increments each cycle with mdu_valid=1 and mdu_ready=0, saturating at MAX_WAIT.
  - Cleared on handshake or when mdu_valid=0.
- pipe_stall:
  - Set at the edge where the counter equals MAX_WAIT-1 and the MDU is still blocked.
  - Cleared at the edge of the MDU handshake, or when mdu_valid drops.
  - While pipe_stall=1 the pipeline must drive pipe_wen=0. If it does not, the MDU still wins and the pipeline write is lost; the bench flags this as a contract violation.
- Busy scoreboard (32 bits; bit0 constant 0):
  - issue_en with issue_dst≠0 sets busy[issue_dst].
  - An MDU handshake clears busy[mdu_waddr].
  - Same-cycle set and clear of the same bit: set wins.
  - Issuing to an already-busy register leaves it busy; only one outstanding MDU op per register is legal.
- rs_busy = busy[rs], rt_busy = busy[rt]: combinational lookup of the registered vector, no same-cycle bypass. A register being cleared this cycle still reads busy=1.
- Pipeline writes never touch the busy vector, including WAW on a busy register.
- resetn low mid-transfer: any in-flight MDU handshake that cycle is discarded; all state returns to its reset values.

Decomposition:
- Shared package:
  - REG_AW=5, REG_DW=32, NREG=32, REG_ZERO=5'd0;
  - default MAX_WAIT.
- Sub-module rf_busy_table: 32-bit scoreboard with set port, clear port and two read ports; the set-wins rule is implemented there.

Test Plan:
- Reset: resetn=0 for 2 cycles with all inputs active -> Regwen=0, mdu_ready=0, pipe_stall=0, rs_busy=rt_busy=0. After release, busy reads 0 for all 32 registers.
- Priority: pipe_wen=1 waddr=3 wdata=0xAAAA0000 and mdu_valid=1 waddr=5 in the same cycle -> waddr=3, mdu_ready=0. Next cycle with pipe_wen=0 -> waddr=5, mdu_ready=1.
- Scoreboard: issue_en dst=8; rs=8 -> rs_busy=1 from the next cycle. MDU handshake to r8 -> rs_busy still 1 that cycle, 0 the cycle after. Simultaneous issue dst=8 and handshake to r8 -> busy stays 1.
- Starvation, MAX_WAIT=4: mdu_valid held and pipe_wen=1 every cycle -> pipe_stall rises after 4 blocked cycles. Pipeline drops pipe_wen -> MDU handshakes; pipe_stall falls the next cycle.
- $0: pipe write waddr=0 -> Regwen=0. MDU request waddr=0 -> mdu_ready=1, Regwen=0, busy unchanged. issue_dst=0 -> rs_busy for rs=0 stays 0.
- Reset mid-operation: busy[4]=1 and pipe_stall=1, then resetn=0 for 1 cycle -> busy cleared, pipe_stall=0, counter=0.
